cmul_seq_ctrl: RTL and testbench

//   Sequencer for a complex multiply (a_re + j*a_im) * (b_re + j*b_im) built on ONE shared
//   W x W signed real multiplier, time-multiplexed over four cycles.

---
 rtl/cmul_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_cmul_seq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmul_seq_ctrl.sv
// cmul_seq_ctrl
//   Sequencer for a complex multiply (a_re + j*a_im) * (b_re + j*b_im) that
//   reuses a single signed W x W multiplier over four cycles:
//     RR: acc_re  = ar*br
//     II: acc_re -= ai*bi
//     RI: acc_im  = ar*bi
//     IR: acc_im += ai*br, results registered, out_valid raised
//   Only one operation is in flight at a time. Minimum issue interval is 6 cycles.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   operand handshake; real_a, imag_a, real_b, imag_b (signed W)
//   out_valid/out_ready result handshake; real_out, imag_out (signed 2W+1)
//   busy                high whenever the sequencer is not in IDLE
//   done_count          results consumed so far, wraps modulo 2^CNT_W
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer holding valid keeps its data stable
// until the transfer. in_ready is high only in IDLE and never during reset.
// out_valid and the result stay stable until the consumer takes them.
// in_ready does not rise in the cycle a result is consumed.

module cmul_seq_ctrl #(
    parameter int W     = 18,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  real_a,
    input  logic signed [W-1:0]  imag_a,
    input  logic signed [W-1:0]  real_b,
    input  logic signed [W-1:0]  imag_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [2*W:0]  real_out,
    output logic signed [2*W:0]  imag_out,
    output logic                 busy,
    output logic [CNT_W-1:0]     done_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RR   = 3'd1,
        S_II   = 3'd2,
        S_RI   = 3'd3,
        S_IR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t state;

    // Operands are captured only on the accept edge.
    logic signed [W-1:0]   ar_q, ai_q, br_q, bi_q;
    logic signed [W-1:0]   mul_a, mul_b;
    logic signed [2*W-1:0] prod;
    logic signed [2*W:0]   prod_ext;
    logic signed [2*W:0]   acc_re, acc_im;

    // Operand selection for the single shared multiplier.
    always_comb begin
        mul_a = ar_q;
        mul_b = br_q;
        case (state)
            S_RR: begin mul_a = ar_q; mul_b = br_q; end
            S_II: begin mul_a = ai_q; mul_b = bi_q; end
            S_RI: begin mul_a = ar_q; mul_b = bi_q; end
            S_IR: begin mul_a = ai_q; mul_b = br_q; end
            default: begin mul_a = ar_q; mul_b = br_q; end
        endcase
    end

    // Size casts on signed operands sign-extend, giving a full 2W product.
    assign prod     = (2*W)'(mul_a) * (2*W)'(mul_b);
    // One extra bit of headroom: min*min + min*min = 2^(2W-1) fits in 2W+1.
    assign prod_ext = {prod[2*W-1], prod};

    assign in_ready = (state == S_IDLE) && !rst;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            real_out   <= '0;
            imag_out   <= '0;
            done_count <= '0;
            acc_re     <= '0;
            acc_im     <= '0;
            ar_q       <= '0;
            ai_q       <= '0;
            br_q       <= '0;
            bi_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        ar_q  <= real_a;
                        ai_q  <= imag_a;
                        br_q  <= real_b;
                        bi_q  <= imag_b;
                        state <= S_RR;
                    end
                end
                S_RR: begin
                    acc_re <= prod_ext;
                    state  <= S_II;
                end
                S_II: begin
                    acc_re <= acc_re - prod_ext;
                    state  <= S_RI;
                end
                S_RI: begin
                    acc_im <= prod_ext;
                    state  <= S_IR;
                end
                S_IR: begin
                    acc_im    <= acc_im + prod_ext;
                    real_out  <= acc_re;
                    imag_out  <= acc_im + prod_ext;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        done_count <= done_count + CNT_W'(1);
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmul_seq_ctrl.sv
// tb_cmul_seq_ctrl
//   Directed bench for cmul_seq_ctrl (W=18, CNT_W=3 so done_count wraps quickly).
//   Inputs change 1 time unit after a rising edge; outputs are sampled on the
//   falling edge. Expected results are pushed into exp_q on accept and popped
//   when a result is consumed.

module tb_cmul_seq_ctrl;

    localparam int W     = 18;
    localparam int CNT_W = 3;
    localparam int OW    = 2*W + 1;
    localparam int EW    = 2*OW;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] real_a, imag_a, real_b, imag_b;
    logic                out_valid;
    logic                out_ready;
    logic signed [OW-1:0] real_out, imag_out;
    logic                busy;
    logic [CNT_W-1:0]    done_count;

    cmul_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .real_a     (real_a),
        .imag_a     (imag_a),
        .real_b     (real_b),
        .imag_b     (imag_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .real_out   (real_out),
        .imag_out   (imag_out),
        .busy       (busy),
        .done_count (done_count)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int               n_vec = 0;
    int               n_err = 0;
    int               cyc = 0;
    logic [EW-1:0]    exp_q[$];
    logic [CNT_W-1:0] done_model = '0;
    int               acc_cyc = 0;
    int               last_acc = -1;
    bit               stream_mode = 1'b0;
    bit               prev_ov = 1'b0;
    bit               consumed_prev = 1'b0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] pk(input longint re, input longint im);
        logic [63:0] r, i;
        r = re;
        i = im;
        return {r[OW-1:0], i[OW-1:0]};
    endfunction

    function automatic logic [EW-1:0] cmul(input int ar, input int ai,
                                           input int br, input int bi);
        longint re, im;
        re = longint'(ar) * longint'(br) - longint'(ai) * longint'(bi);
        im = longint'(ar) * longint'(bi) + longint'(ai) * longint'(br);
        return pk(re, im);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0]        e;
        logic signed [OW-1:0] e_re, e_im;
        cyc++;
        if (rst) begin
            exp_q.delete();
            done_model    = '0;
            prev_ov       = 1'b0;
            consumed_prev = 1'b0;
            last_acc      = -1;
        end else begin
            if (consumed_prev) check("ready_after_consume", in_ready, 1);
            consumed_prev = 1'b0;
            if (out_valid) check("no_ready_while_out", in_ready, 0);
            if (in_valid && in_ready) begin
                if (stream_mode && last_acc >= 0) check("issue_interval", cyc - last_acc, 6);
                last_acc = cyc;
                acc_cyc  = cyc;
            end
            if (out_valid && !prev_ov) check("latency", cyc - acc_cyc, 5);
            prev_ov = out_valid;
            if (out_valid && out_ready) begin
                check("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    e_re = e[EW-1:OW];
                    e_im = e[OW-1:0];
                    check("real_out", real_out, e_re);
                    check("imag_out", imag_out, e_im);
                end
                check("done_count_pre", done_count, done_model);
                done_model++;
                consumed_prev = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input logic [EW-1:0] exp);
        int n;
        @(posedge clk); #1;
        real_a   = W'(ar);
        imag_a   = W'(ai);
        real_b   = W'(br);
        imag_b   = W'(bi);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("tmo_accept", in_ready, 1);
        else exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble operands while busy; the result in flight must not change.
        real_a = W'($urandom);
        imag_a = W'($urandom);
        real_b = W'($urandom);
        imag_b = W'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("tmo_drain", out_valid, 0);
    endtask

    function automatic int rnd_op();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int ar, ai, br, bi;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        real_a    = '0;
        imag_a    = '0;
        real_b    = '0;
        imag_b    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_real_out", real_out, 0);
        check("rst_imag_out", imag_out, 0);
        check("rst_done_count", done_count, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        // Idle without in_valid stays idle
        repeat (4) begin
            @(negedge clk);
            check("idle_hold_busy", busy, 0);
        end

        // (3+4j)*(1-2j) = 11-2j; j*j = -1
        send(3, 4, 1, -2, pk(11, -2));
        wait_drain();
        send(0, 1, 0, 1, pk(-1, 0));
        wait_drain();

        // Extremes
        send(-131072, -131072, -131072, -131072, pk(0, 64'sd34359738368));
        wait_drain();
        send(131071, -131072, 131071, -131072, pk(-262143, -64'sd34359476224));
        wait_drain();

        // Backpressure: (5-7j)*(-3+2j) = -1+31j
        out_ready = 1'b0;
        send(5, -7, -3, 2, pk(-1, 31));
        n = 0;
        while (!out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("bp_out_valid_seen", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_real_out", real_out, -1);
            check("bp_imag_out", imag_out, 31);
            check("bp_done_count", done_count, done_model);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain();
        check("bp_done_after", done_count, done_model);

        // Back-to-back stream of 20 random operations
        stream_mode = 1'b1;
        last_acc    = -1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ar = rnd_op();
            ai = rnd_op();
            br = rnd_op();
            bi = rnd_op();
            real_a = W'(ar);
            imag_a = W'(ai);
            real_b = W'(br);
            imag_b = W'(bi);
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            if (n >= 50) check("tmo_stream_accept", in_ready, 1);
            else exp_q.push_back(cmul(ar, ai, br, bi));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain();
        stream_mode = 1'b0;

        // Reset in the RI state aborts the operation
        @(negedge clk);
        check("pre_abort_done_count", done_count, 1);
        send(1000, 2000, 3000, 4000, cmul(1000, 2000, 3000, 4000));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy_before", busy, 1);
        check("abort_in_ready_rst", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_done_count", done_count, 0);
        check("abort_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_out_valid", out_valid, 0);
        end
        // (-100+200j)*(300-400j) = 50000+100000j
        send(-100, 200, 300, -400, pk(50000, 100000));
        wait_drain();

        // Eight more operations: 9 since reset, done_count wraps 7 -> 0 -> 1
        for (int i = 0; i < 8; i++) begin
            ar = rnd_op();
            ai = rnd_op();
            br = rnd_op();
            bi = rnd_op();
            send(ar, ai, br, bi, cmul(ar, ai, br, bi));
            wait_drain();
        end
        @(negedge clk);
        check("wrap_final", done_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
